pipeline_control_unit: RTL and testbench
========================================

PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 Parameter REG_ADDR_W, default 5, register-address width.
REQ-002 Parameter CNT_W, default 16, performance-counter width.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 id_valid  input  1  ID holds a valid instruction.
REQ-007 id_write, id_load, id_store  input  1 each  decoded write/load/store controls.
REQ-008 id_uses_rs1, id_uses_rs2  input  1 each  source operand is read.
REQ-009 id_rs1, id_rs2, id_rd  input  REG_ADDR_W each  ID register addresses.
REQ-010 ex_redirect  input  1  EX resolved taken branch, jal or jalr.
REQ-011 dmem_ready  input  1  data memory completes this cycle.
REQ-012 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  stage-register enables.
REQ-013 if_id_flush, id_ex_flush  output  1 each  load bubble into IF/ID, ID/EX.
REQ-014 forward_a, forward_b  output  2 each  EX operand source: 0 regfile, 1 EX/MEM, 2 MEM/WB.
REQ-015 rf_write  output  1  register-file write enable in WB.
REQ-016 stall_count, flush_count  output  CNT_W each  performance counters.

Function
REQ-017 Internal shadow registers SHALL track, per EX/MEM/WB stage: valid, write, load, store, rd; EX also rs1, rs2, uses_rs1, uses_rs2.
REQ-018 FSM states SHALL be RUN and MEM_WAIT.
REQ-019 RUN -> MEM_WAIT when MEM valid, (load|store), dmem_ready=0; MEM_WAIT -> RUN on the cycle dmem_ready=1.
REQ-020 Freeze (MEM access with dmem_ready=0): all five enables 0, both flushes 0, shadow registers hold, counters unchanged except stall_count.
REQ-021 Load-use: id_valid, EX valid & load, EX rd!=0, and rd equals a used ID source -> pc_en=0, if_id_en=0, id_ex_flush=1, other enables 1.
REQ-022 Redirect: ex_redirect=1 -> if_id_flush=1, id_ex_flush=1, all enables 1; redirect overrides load-use.
REQ-023 Priority: freeze > redirect > load-use > normal advance.
REQ-024 Normal advance: all enables 1, flushes 0; shadows shift ID->EX->MEM->WB.
REQ-025 Flushed or stalled slot SHALL enter EX as valid=0.
REQ-026 forward_x=1 when MEM valid & write & rd!=0 & rd==EX rsx & EX uses_rsx; else 2 when same test on WB; else 0; EX/MEM wins ties.
REQ-027 Forwarding outputs SHALL be combinational from shadow registers, forced to 0 when EX invalid.
REQ-028 rf_write = WB valid & WB write, masked to 0 during freeze.
REQ-029 x0 as rd never causes stall or forwarding.
REQ-030 stall_count +1 per freeze or load-use cycle; flush_count +1 per redirect cycle; both saturate at all-ones, no wrap.
REQ-031 Latency: stall/flush/enable outputs combinational same-cycle; shadow update on next rising edge.

Reset
REQ-032 rst_n low: all stage valids 0, FSM RUN, counters 0; outputs then: enables 1, flushes 0, forwards 0, rf_write 0.
REQ-033 Reset mid-MEM_WAIT or mid-stall SHALL abandon the operation with no pending state kept.

Structure
REQ-034 Shared package pipeline_pkg SHALL hold FSM state enum, forward-select enum (FWD_RF=0, FWD_MEM=1, FWD_WB=2) and REG_ADDR_W default.
REQ-035 Forwarding logic SHALL be one combinational sub-module, forwarding_unit, instantiated once per operand.

Verification
REQ-036 lw x5 then add x6,x5,x1 -> one cycle pc_en=0, id_ex_flush=1; next cycle forward_a=2; stall_count=1.
REQ-037 add x3,x1,x2 then sub x4,x3,x3 -> no stall, forward_a=1, forward_b=1.
REQ-038 ex_redirect=1 with load-use true -> if_id_flush=1, id_ex_flush=1, pc_en=1; flush_count=1, stall_count=0.
REQ-039 lw in MEM, dmem_ready=0 for 3 cycles -> enables 0 three cycles, state MEM_WAIT, stall_count=3; resume on ready.
REQ-040 lw x0 followed by use of x0 -> no stall, forward 0.
REQ-041 Counter preset to all-ones by forcing 2^CNT_W stalls -> stays all-ones; rst_n low mid-MEM_WAIT -> state RUN, counts 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline control logic.
//   - pcu_state_e : control FSM states (normal run / waiting on data memory)
//   - fwd_sel_e   : EX operand source select (register file, EX/MEM, MEM/WB)
//   - REG_ADDR_W_DEFAULT : default register-address width
package pipeline_pkg;

    localparam int unsigned REG_ADDR_W_DEFAULT = 5;

    typedef enum logic [0:0] {
        StRun,
        StMemWait
    } pcu_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/forwarding_unit.sv
// Operand forwarding select for one EX source operand (purely combinational).
// Ports:
//   ex_valid, ex_uses_rs, ex_rs    : EX instruction valid, operand read, operand register
//   mem_valid, mem_write, mem_rd   : instruction in MEM
//   wb_valid, wb_write, wb_rd      : instruction in WB
//   fwd_sel                        : FWD_MEM if the MEM result matches, else FWD_WB, else FWD_RF
module forwarding_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
    input  logic                  ex_valid,
    input  logic                  ex_uses_rs,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic                  mem_valid,
    input  logic                  mem_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_valid,
    input  logic                  wb_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output fwd_sel_e              fwd_sel
);

    logic mem_hit;
    logic wb_hit;

    // x0 is hard-wired zero, so a write to it is never a forwarding source.
    assign mem_hit = mem_valid & mem_write & (mem_rd != '0) & (mem_rd == ex_rs);
    assign wb_hit  = wb_valid & wb_write & (wb_rd != '0) & (wb_rd == ex_rs);

    always_comb begin
        fwd_sel = FWD_RF;
        if (ex_valid && ex_uses_rs) begin
            // The younger result (EX/MEM) wins when both stages match.
            if (mem_hit) begin
                fwd_sel = FWD_MEM;
            end else if (wb_hit) begin
                fwd_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_control_unit.sv
// Hazard and stall control for a five-stage in-order pipeline.
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   id_*                              : decoded instruction currently in ID
//   ex_redirect                       : EX resolved a taken control transfer
//   dmem_ready                        : data memory completes this cycle
//   pc_en .. mem_wb_en                : stage-register enables
//   if_id_flush, id_ex_flush          : bubble insertion into IF/ID, ID/EX
//   forward_a, forward_b              : EX operand source selects
//   rf_write                          : register-file write enable in WB
//   stall_count, flush_count          : saturating performance counters
module pipeline_control_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEFAULT,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_write,
    input  logic                  id_load,
    input  logic                  id_store,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_redirect,
    input  logic                  dmem_ready,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  rf_write,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    pcu_state_e state_q;

    // Shadow copies of the control fields held in each downstream stage.
    logic                  ex_valid_q, ex_write_q, ex_load_q, ex_store_q;
    logic                  ex_uses_rs1_q, ex_uses_rs2_q;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
    logic                  mem_valid_q, mem_write_q, mem_load_q, mem_store_q;
    logic [REG_ADDR_W-1:0] mem_rd_q;
    logic                  wb_valid_q, wb_write_q, wb_load_q, wb_store_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;

    logic [CNT_W-1:0] stall_count_q, flush_count_q;

    logic     freeze;
    logic     load_use_hit;
    logic     stall_evt;
    logic     flush_evt;
    fwd_sel_e fwd_a, fwd_b;
    logic     unused_wb;

    // WB load/store flags are tracked for completeness but not consumed here.
    assign unused_wb = wb_load_q ^ wb_store_q;

    assign freeze = mem_valid_q & (mem_load_q | mem_store_q) & ~dmem_ready;

    assign load_use_hit = id_valid & ex_valid_q & ex_load_q & (ex_rd_q != '0) &
                          ((id_uses_rs1 & (id_rs1 == ex_rd_q)) |
                           (id_uses_rs2 & (id_rs2 == ex_rd_q)));

    assign flush_evt = ~freeze & ex_redirect;
    assign stall_evt = freeze | (~ex_redirect & load_use_hit);

    // Priority: freeze > redirect > load-use > normal advance.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (freeze) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use_hit) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    assign rf_write = wb_valid_q & wb_write_q & ~freeze;

    forwarding_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_a (
        .ex_valid   (ex_valid_q),
        .ex_uses_rs (ex_uses_rs1_q),
        .ex_rs      (ex_rs1_q),
        .mem_valid  (mem_valid_q),
        .mem_write  (mem_write_q),
        .mem_rd     (mem_rd_q),
        .wb_valid   (wb_valid_q),
        .wb_write   (wb_write_q),
        .wb_rd      (wb_rd_q),
        .fwd_sel    (fwd_a)
    );

    forwarding_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_b (
        .ex_valid   (ex_valid_q),
        .ex_uses_rs (ex_uses_rs2_q),
        .ex_rs      (ex_rs2_q),
        .mem_valid  (mem_valid_q),
        .mem_write  (mem_write_q),
        .mem_rd     (mem_rd_q),
        .wb_valid   (wb_valid_q),
        .wb_write   (wb_write_q),
        .wb_rd      (wb_rd_q),
        .fwd_sel    (fwd_b)
    );

    assign forward_a = fwd_a;
    assign forward_b = fwd_b;

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            unique case (state_q)
                StRun:     if (freeze) state_q <= StMemWait;
                StMemWait: if (dmem_ready) state_q <= StRun;
                default:   state_q <= StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_write_q    <= 1'b0;
            ex_load_q     <= 1'b0;
            ex_store_q    <= 1'b0;
            ex_uses_rs1_q <= 1'b0;
            ex_uses_rs2_q <= 1'b0;
            ex_rd_q       <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            mem_valid_q   <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_load_q    <= 1'b0;
            mem_store_q   <= 1'b0;
            mem_rd_q      <= '0;
            wb_valid_q    <= 1'b0;
            wb_write_q    <= 1'b0;
            wb_load_q     <= 1'b0;
            wb_store_q    <= 1'b0;
            wb_rd_q       <= '0;
        end else if (!freeze) begin
            wb_valid_q    <= mem_valid_q;
            wb_write_q    <= mem_write_q;
            wb_load_q     <= mem_load_q;
            wb_store_q    <= mem_store_q;
            wb_rd_q       <= mem_rd_q;
            mem_valid_q   <= ex_valid_q;
            mem_write_q   <= ex_write_q;
            mem_load_q    <= ex_load_q;
            mem_store_q   <= ex_store_q;
            mem_rd_q      <= ex_rd_q;
            // A flushed or held-back ID slot enters EX as a bubble.
            ex_valid_q    <= id_valid & ~id_ex_flush;
            ex_write_q    <= id_write;
            ex_load_q     <= id_load;
            ex_store_q    <= id_store;
            ex_uses_rs1_q <= id_uses_rs1;
            ex_uses_rs2_q <= id_uses_rs2;
            ex_rd_q       <= id_rd;
            ex_rs1_q      <= id_rs1;
            ex_rs2_q      <= id_rs2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (stall_evt && (stall_count_q != '1)) stall_count_q <= stall_count_q + 1'b1;
            if (flush_evt && (flush_count_q != '1)) flush_count_q <= flush_count_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit: each stimulus cycle pushes its
// hand-computed expected outputs; a monitor pops and compares every cycle.
module tb_pipeline_control_unit;
    import pipeline_pkg::*;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;

    localparam logic [4:0] EN_ALL = 5'b11111;
    localparam logic [4:0] EN_LU  = 5'b00111;
    localparam logic [4:0] EN_FRZ = 5'b00000;
    localparam logic [1:0] FL_NO  = 2'b00;
    localparam logic [1:0] FL_LU  = 2'b01;
    localparam logic [1:0] FL_RD  = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0, id_write = 1'b0, id_load = 1'b0, id_store = 1'b0;
    logic          id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          ex_redirect = 1'b0, dmem_ready = 1'b1;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic          if_id_flush, id_ex_flush;
    logic [1:0]    forward_a, forward_b;
    logic          rf_write;
    logic [CW-1:0] stall_count, flush_count;

    typedef struct {
        logic          valid, write, load, store, u1, u2;
        logic [AW-1:0] rs1, rs2, rd;
    } insn_t;

    typedef struct {
        string      name;
        logic [4:0] en;
        logic [1:0] fl;
        logic [1:0] fa, fb;
        logic       rfw;
        int         sc, fc, st; // st: -1 unchecked, 0 RUN, 1 MEM_WAIT
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    pipeline_control_unit #(
        .REG_ADDR_W (AW),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_write    (id_write),
        .id_load     (id_load),
        .id_store    (id_store),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .ex_redirect (ex_redirect),
        .dmem_ready  (dmem_ready),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .id_ex_en    (id_ex_en),
        .ex_mem_en   (ex_mem_en),
        .mem_wb_en   (mem_wb_en),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .forward_a   (forward_a),
        .forward_b   (forward_b),
        .rf_write    (rf_write),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    always #5 clk = ~clk;

    function automatic insn_t mk_insn(input logic v, input logic w, input logic l,
                                      input logic s, input logic u1, input logic u2,
                                      input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                      input logic [AW-1:0] rd);
        insn_t i;
        i.valid = v; i.write = w; i.load = l; i.store = s; i.u1 = u1; i.u2 = u2;
        i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
        return i;
    endfunction

    function automatic insn_t nop();
        return mk_insn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic insn_t alu(input int rd, input int rs1, input int rs2);
        return mk_insn(1, 1, 0, 0, 1, 1, AW'(rs1), AW'(rs2), AW'(rd));
    endfunction

    function automatic insn_t lw(input int rd, input int rs1);
        return mk_insn(1, 1, 1, 0, 1, 0, AW'(rs1), 0, AW'(rd));
    endfunction

    function automatic insn_t sw(input int rs1, input int rs2);
        return mk_insn(1, 0, 0, 1, 1, 1, AW'(rs1), AW'(rs2), 0);
    endfunction

    function automatic exp_t mk_exp(input string name, input logic [4:0] en,
                                    input logic [1:0] fl, input int fa, input int fb,
                                    input logic rfw, input int sc, input int fc, input int st);
        exp_t e;
        e.name = name; e.en = en; e.fl = fl; e.fa = 2'(fa); e.fb = 2'(fb);
        e.rfw = rfw; e.sc = sc; e.fc = fc; e.st = st;
        return e;
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue its expectation.
    task automatic step(input insn_t i, input logic redir, input logic rdy, input logic rst,
                        input exp_t e);
        @(negedge clk);
        rst_n       = ~rst;
        id_valid    = i.valid;
        id_write    = i.write;
        id_load     = i.load;
        id_store    = i.store;
        id_uses_rs1 = i.u1;
        id_uses_rs2 = i.u2;
        id_rs1      = i.rs1;
        id_rs2      = i.rs2;
        id_rd       = i.rd;
        ex_redirect = redir;
        dmem_ready  = rdy;
        exp_q.push_back(e);
    endtask

    // Monitor: samples 2 time units after the falling edge, well clear of posedge.
    initial begin : monitor
        exp_t       e;
        logic [4:0] got_en;
        logic [1:0] got_fl;
        int         got_st;
        logic       bad;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e      = exp_q.pop_front();
                got_en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
                got_fl = {if_id_flush, id_ex_flush};
                got_st = (dut.state_q == StMemWait) ? 1 : 0;
                bad = (got_en !== e.en) || (got_fl !== e.fl) || (forward_a !== e.fa) ||
                      (forward_b !== e.fb) || (rf_write !== e.rfw) ||
                      (int'(stall_count) != e.sc) || (int'(flush_count) != e.fc) ||
                      ((e.st >= 0) && (got_st != e.st));
                n_cmp++;
                if (bad) begin
                    n_bad++;
                    $display("FAIL %s: got en=%b fl=%b fa=%0d fb=%0d rfw=%b sc=%0d fc=%0d st=%0d ; want en=%b fl=%b fa=%0d fb=%0d rfw=%b sc=%0d fc=%0d st=%0d",
                             e.name, got_en, got_fl, forward_a, forward_b, rf_write,
                             stall_count, flush_count, got_st, e.en, e.fl, e.fa, e.fb,
                             e.rfw, e.sc, e.fc, e.st);
                end
            end
        end
    end

    initial begin : stimulus
        // Reset state.
        step(nop(), 0, 1, 1, mk_exp("reset", EN_ALL, FL_NO, 0, 0, 0, 0, 0, 0));

        // lw x5 ; add x6,x5,x1 -> one load-use stall, later WB forward.
        step(lw(5, 1),    0, 1, 0, mk_exp("lu_issue",  EN_ALL, FL_NO, 0, 0, 0, 0, 0, 0));
        step(alu(6, 5, 1), 0, 1, 0, mk_exp("lu_stall",  EN_LU,  FL_LU, 0, 0, 0, 0, 0, 0));
        step(alu(6, 5, 1), 0, 1, 0, mk_exp("lu_replay", EN_ALL, FL_NO, 0, 0, 0, 1, 0, 0));
        step(nop(),        0, 1, 0, mk_exp("lu_fwd_wb", EN_ALL, FL_NO, 2, 0, 1, 1, 0, 0));
        step(nop(),        0, 1, 0, mk_exp("lu_drain",  EN_ALL, FL_NO, 0, 0, 0, 1, 0, -1));
        step(nop(),        0, 1, 1, mk_exp("reset2",    EN_ALL, FL_NO, 0, 0, 0, 0, 0, 0));

        // add x3,x1,x2 ; sub x4,x3,x3 -> MEM forward on both; tie case x7.
        step(alu(3, 1, 2), 0, 1, 0, mk_exp("alu_a1", EN_ALL, FL_NO, 0, 0, 0, 0, 0, 0));
        step(alu(4, 3, 3), 0, 1, 0, mk_exp("alu_a2", EN_ALL, FL_NO, 0, 0, 0, 0, 0, 0));
        step(nop(),        0, 1, 0, mk_exp("alu_fwd_mem", EN_ALL, FL_NO, 1, 1, 0, 0, 0, 0));
        step(alu(7, 1, 1), 0, 1, 0, mk_exp("alu_a4", EN_ALL, FL_NO, 0, 0, 1, 0, 0, 0));
        step(alu(7, 2, 2), 0, 1, 0, mk_exp("alu_a5", EN_ALL, FL_NO, 0, 0, 1, 0, 0, 0));
        step(alu(8, 7, 2), 0, 1, 0, mk_exp("alu_a6", EN_ALL, FL_NO, 0, 0, 0, 0, 0, 0));
        step(nop(),        0, 1, 0, mk_exp("fwd_tie_mem", EN_ALL, FL_NO, 1, 0, 1, 0, 0, 0));
        step(nop(),        0, 1, 0, mk_exp("alu_a8", EN_ALL, FL_NO, 0, 0, 1, 0, 0, 0));
        step(nop(),        0, 1, 0, mk_exp("alu_a9", EN_ALL, FL_NO, 0, 0, 1, 0, 0, 0));

        // Redirect overriding a load-use hazard.
        step(lw(5, 1),     0, 1, 0, mk_exp("rd_issue",   EN_ALL, FL_NO, 0, 0, 0, 0, 0, 0));
        step(alu(6, 5, 1), 1, 1, 0, mk_exp("rd_over_lu", EN_ALL, FL_RD, 0, 0, 0, 0, 0, 0));
        step(nop(),        0, 1, 0, mk_exp("rd_after",   EN_ALL, FL_NO, 0, 0, 0, 0, 1, 0));
        step(nop(),        0, 1, 0, mk_exp("rd_wb",      EN_ALL, FL_NO, 0, 0, 1, 0, 1, 0));

        // Load waits three cycles in MEM; older add in WB must hold and stay masked.
        step(alu(9, 2, 2), 0, 1, 0, mk_exp("mw_c1", EN_ALL, FL_NO, 0, 0, 0, 0, 1, 0));
        step(lw(5, 1),     0, 1, 0, mk_exp("mw_c2", EN_ALL, FL_NO, 0, 0, 0, 0, 1, 0));
        step(nop(),        0, 1, 0, mk_exp("mw_c3", EN_ALL, FL_NO, 0, 0, 0, 0, 1, 0));
        step(nop(),        0, 0, 0, mk_exp("mw_frz1", EN_FRZ, FL_NO, 0, 0, 0, 0, 1, 0));
        step(nop(),        0, 0, 0, mk_exp("mw_frz2", EN_FRZ, FL_NO, 0, 0, 0, 1, 1, 1));
        step(nop(),        0, 0, 0, mk_exp("mw_frz3", EN_FRZ, FL_NO, 0, 0, 0, 2, 1, 1));
        step(nop(),        0, 1, 0, mk_exp("mw_resume", EN_ALL, FL_NO, 0, 0, 1, 3, 1, 1));
        step(nop(),        0, 1, 0, mk_exp("mw_run",    EN_ALL, FL_NO, 0, 0, 1, 3, 1, 0));

        // lw x0 followed by use of x0: no stall, no forward.
        step(lw(0, 1),     0, 1, 0, mk_exp("x0_issue", EN_ALL, FL_NO, 0, 0, 0, 3, 1, 0));
        step(alu(6, 0, 0), 0, 1, 0, mk_exp("x0_nostall", EN_ALL, FL_NO, 0, 0, 0, 3, 1, 0));
        step(nop(),        0, 1, 0, mk_exp("x0_nofwd", EN_ALL, FL_NO, 0, 0, 0, 3, 1, 0));
        step(nop(),        0, 1, 0, mk_exp("x0_wb1", EN_ALL, FL_NO, 0, 0, 1, 3, 1, 0));
        step(nop(),        0, 1, 0, mk_exp("x0_wb2", EN_ALL, FL_NO, 0, 0, 1, 3, 1, 0));

        // Saturate stall_count with a long store wait; a redirect inside a freeze is ignored.
        step(nop(), 0, 1, 1, mk_exp("reset3", EN_ALL, FL_NO, 0, 0, 0, 0, 0, 0));
        step(sw(1, 2), 0, 1, 0, mk_exp("sat_issue", EN_ALL, FL_NO, 0, 0, 0, 0, 0, 0));
        step(nop(),    0, 1, 0, mk_exp("sat_to_mem", EN_ALL, FL_NO, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 18; k++) begin
            step(nop(), (k == 5) ? 1'b1 : 1'b0, 0, 0,
                 mk_exp($sformatf("sat_frz_%0d", k), EN_FRZ, FL_NO, 0, 0, 0,
                        (k < 15) ? k : 15, 0, (k == 0) ? 0 : 1));
        end

        // Reset while waiting on memory abandons the access.
        step(nop(), 0, 0, 1, mk_exp("rst_mid_wait", EN_ALL, FL_NO, 0, 0, 0, 0, 0, 0));
        step(nop(), 0, 0, 0, mk_exp("post_rst",     EN_ALL, FL_NO, 0, 0, 0, 0, 0, 0));
        step(nop(), 0, 1, 0, mk_exp("post_rst2",    EN_ALL, FL_NO, 0, 0, 0, 0, 0, 0));

        // Bounded drain of the scoreboard.
        repeat (3) @(negedge clk);
        #4;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
